// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - single-channel word-copy DMA with a 16-byte register window and a registered bus initiator port
module bus_dma #(
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  output logic        bus_wen,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_done,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]  state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic [15:0] rem;
  logic [31:0] buffer;
  logic        done;
  logic        aborted;
  logic        abort_req;
  logic        issue;
  logic        zero_done;

  logic        busy;
  logic        wr_hit;
  logic        ctrl_wr;
  logic        start;
  logic        rd_fin;
  logic        wr_fin;
  logic        done_set;
  logic [31:0] rd_val;
  logic [31:0] src_new;
  logic [31:0] dst_new;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign active   = (addr[31:4] == BASE_ADDR[31:4]);
  assign busy     = (state != S_IDLE);
  assign wr_hit   = wen & active;
  assign ctrl_wr  = wr_hit & (addr[3:2] == 2'd3) & wmask[0];
  assign start    = ctrl_wr & wdata[0] & ~busy;
  assign rd_fin   = (state == S_RD) & bus_ren & bus_done;
  assign wr_fin   = (state == S_WR) & bus_wen & bus_done;
  // A pending abort on the last word still ends as aborted, so done is only set on a clean finish.
  assign done_set = zero_done | (wr_fin & (rem == 16'd1) & ~abort_req);
  assign irq      = done;

  assign src_new = merge(src, wdata, wmask) & 32'hFFFF_FFFC;
  assign dst_new = merge(dst, wdata, wmask) & 32'hFFFF_FFFC;

  always_comb begin
    rd_val = 32'h0;
    case (addr[3:2])
      2'd0:    rd_val = src;
      2'd1:    rd_val = dst;
      2'd2:    rd_val = {16'h0, len};
      default: rd_val = {rem, 13'h0, aborted, done, busy};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      src       <= 32'h0;
      dst       <= 32'h0;
      len       <= 16'h0;
      rem       <= 16'h0;
      buffer    <= 32'h0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      abort_req <= 1'b0;
      issue     <= 1'b0;
      zero_done <= 1'b0;
      ready     <= 1'b0;
      rdata     <= 32'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_wmask <= 4'h0;
      bus_wen   <= 1'b0;
      bus_ren   <= 1'b0;
    end else begin
      ready     <= (wen | ren) & active;
      rdata     <= (ren & active) ? rd_val : 32'h0;
      zero_done <= start & (len == 16'h0);

      if (done_set) begin
        done <= 1'b1;
      end else if (ctrl_wr & wdata[1]) begin
        done <= 1'b0;
      end

      if (wr_hit & ~busy) begin
        case (addr[3:2])
          2'd0: src <= src_new;
          2'd1: dst <= dst_new;
          2'd2: begin
            if (wmask[0]) len[7:0]  <= wdata[7:0];
            if (wmask[1]) len[15:8] <= wdata[15:8];
          end
          default: ;
        endcase
      end

      if (ctrl_wr & wdata[2] & busy) abort_req <= 1'b1;

      // Each strobe rises one edge after 'issue' is set, which gives the idle cycle between transactions.
      case (state)
        S_IDLE: begin
          if (start) begin
            aborted   <= 1'b0;
            abort_req <= 1'b0;
            if (len != 16'h0) begin
              state <= S_RD;
              rem   <= len;
              issue <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (issue) begin
            bus_ren  <= 1'b1;
            bus_addr <= src;
            issue    <= 1'b0;
          end else if (rd_fin) begin
            bus_ren <= 1'b0;
            buffer  <= bus_rdata;
            if (abort_req) begin
              state     <= S_IDLE;
              aborted   <= 1'b1;
              abort_req <= 1'b0;
            end else begin
              state <= S_WR;
              issue <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (issue) begin
            bus_wen   <= 1'b1;
            bus_wmask <= 4'hF;
            bus_addr  <= dst;
            bus_wdata <= buffer;
            issue     <= 1'b0;
          end else if (wr_fin) begin
            bus_wen   <= 1'b0;
            bus_wmask <= 4'h0;
            src       <= src + 32'd4;
            dst       <= dst + 32'd4;
            rem       <= rem - 16'd1;
            if (abort_req) begin
              state     <= S_IDLE;
              aborted   <= 1'b1;
              abort_req <= 1'b0;
            end else if (rem == 16'd1) begin
              state <= S_IDLE;
            end else begin
              state <= S_RD;
              issue <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - directed bench for bus_dma with a latency-configurable bus responder
module tb_bus_dma;

  localparam logic [31:0] BASE = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  wmask, bus_wmask;
  logic        wen, ren, ready, active, bus_wen, bus_ren, bus_done, irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  int lat_lo = 0, lat_hi = 0, wait_cnt = 0, low_cnt = 2;
  logic p_ren = 0, p_wen = 0, p_done = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;

  bus_dma #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
    .rdata(rdata), .ready(ready), .active(active),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata),
    .bus_done(bus_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Responder and protocol monitor share one negedge process so done/log ordering is deterministic.
  always @(negedge clk) begin
    if (rst) begin
      bus_done = 1'b0;
      p_ren = 0; p_wen = 0; p_done = 0;
      low_cnt = 2;
      wait_cnt = lat_lo;
    end else begin
      if (bus_ren | bus_wen) chk("ren_wen_excl", {31'b0, bus_ren & bus_wen}, 32'h0);
      if (p_done) begin
        chk("drop_after_done", {30'b0, bus_ren, bus_wen}, 32'h0);
      end else if (p_ren | p_wen) begin
        chk("strobe_hold", {30'b0, bus_ren, bus_wen}, {30'b0, p_ren, p_wen});
        chk("addr_hold", bus_addr, p_addr);
        if (p_wen) chk("wdata_hold", bus_wdata, p_wdata);
      end
      if (bus_wen && !p_wen) begin
        chk("gap_before_wr", 32'(low_cnt), 32'd1);
        chk("wmask_wr", {28'h0, bus_wmask}, 32'hF);
      end
      low_cnt = (bus_ren | bus_wen) ? 0 : low_cnt + 1;
      p_ren = bus_ren; p_wen = bus_wen; p_addr = bus_addr; p_wdata = bus_wdata;
      if (bus_done) begin
        bus_done = 1'b0;
      end else if (bus_ren | bus_wen) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          if (bus_ren) begin
            rd_q.push_back(bus_addr);
            bus_rdata = mem_rd(bus_addr);
          end else begin
            wa_q.push_back(bus_addr);
            wd_q.push_back(bus_wdata);
            mem[bus_addr] = bus_wdata;
          end
          bus_done = 1'b1;
          wait_cnt = $urandom_range(lat_hi, lat_lo);
        end
      end
      p_done = bus_done;
    end
  end

  task automatic set_lat(input int lo, input int hi);
    lat_lo = lo; lat_hi = hi; wait_cnt = lo;
  endtask

  task automatic cpu_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = BASE + {28'h0, off}; wdata = d; wmask = m; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0; addr = 32'h0;
  endtask

  task automatic cpu_read(input logic [3:0] off, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    addr = BASE + {28'h0, off}; ren = 1'b1;
    @(negedge clk);
    d = rdata; rdy = ready;
    ren = 1'b0; addr = 32'h0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    logic r;
    st = 32'h1;
    for (int i = 0; i < 400; i++) begin
      cpu_read(4'hC, st, r);
      if (!st[0]) break;
    end
    chk(tag, {31'b0, st[0]}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic r;
    int rd0, wa0;
    bit found;

    rst = 1'b1; addr = 0; wdata = 0; wmask = 0; wen = 0; ren = 0; bus_rdata = 0; bus_done = 0;
    set_lat(0, 0);
    repeat (2) @(negedge clk);
    chk("rst_bus_ren", {31'b0, bus_ren}, 0);
    chk("rst_bus_wen", {31'b0, bus_wen}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_irq_ready", {30'b0, irq, ready}, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    addr = BASE; #1 chk("active_in", {31'b0, active}, 1);
    addr = BASE + 32'h10; #1 chk("active_above", {31'b0, active}, 0);
    addr = BASE - 32'h4; #1 chk("active_below", {31'b0, active}, 0);
    addr = 0;
    cpu_read(4'hC, d, r);
    chk("rst_status", d, 32'h0);

    // masked byte writes, low address bits forced to zero, one-cycle ready
    cpu_write(4'h0, 32'h1234_5677, 4'hF);
    cpu_write(4'h0, 32'hAABB_CCDD, 4'b0010);
    cpu_read(4'h0, d, r);
    chk("src_masked", d, 32'h1234_CC74);
    chk("ready_pulse", {31'b0, r}, 1);
    @(negedge clk);
    chk("ready_drop", {31'b0, ready}, 0);
    chk("rdata_idle", rdata, 0);
    cpu_write(4'h8, 32'hFFFF_0203, 4'b0001);
    cpu_read(4'h8, d, r);
    chk("len_masked", d, 32'h0000_0003);

    // basic 3-word copy
    cpu_write(4'h0, 32'h100, 4'hF);
    cpu_write(4'h4, 32'h200, 4'hF);
    cpu_write(4'h8, 32'd3, 4'hF);
    rd0 = rd_q.size(); wa0 = wa_q.size();
    cpu_write(4'hC, 32'h1, 4'hF);
    wait_idle("basic_idle");
    chk("basic_nrd", 32'(rd_q.size() - rd0), 3);
    chk("basic_nwr", 32'(wa_q.size() - wa0), 3);
    if (rd_q.size() >= rd0 + 3 && wa_q.size() >= wa0 + 3) begin
      chk("basic_rd0", rd_q[rd0], 32'h100);
      chk("basic_rd2", rd_q[rd0+2], 32'h108);
      chk("basic_wa0", wa_q[wa0], 32'h200);
      chk("basic_wa2", wa_q[wa0+2], 32'h208);
      chk("basic_wd0", wd_q[wa0], 32'h5A5A_0100);
      chk("basic_wd2", wd_q[wa0+2], 32'h5A5A_0108);
    end
    cpu_read(4'hC, d, r);
    chk("basic_status", d, 32'h0000_0002);
    chk("basic_irq", {31'b0, irq}, 1);
    cpu_read(4'h0, d, r);
    chk("basic_src_end", d, 32'h10C);

    cpu_write(4'hC, 32'h2, 4'hF);
    cpu_read(4'hC, d, r);
    chk("clear_done", d, 32'h0);
    chk("clear_irq", {31'b0, irq}, 0);

    // random latency 0..4
    set_lat(0, 4);
    cpu_write(4'h0, 32'h1000, 4'hF);
    cpu_write(4'h4, 32'h2000, 4'hF);
    cpu_write(4'h8, 32'd5, 4'hF);
    rd0 = rd_q.size(); wa0 = wa_q.size();
    cpu_write(4'hC, 32'h1, 4'hF);
    wait_idle("rand_idle");
    chk("rand_nrd", 32'(rd_q.size() - rd0), 5);
    chk("rand_nwr", 32'(wa_q.size() - wa0), 5);
    if (wa_q.size() >= wa0 + 5) begin
      chk("rand_wa4", wa_q[wa0+4], 32'h2010);
      chk("rand_wd4", wd_q[wa0+4], 32'h5A5A_1010);
    end
    cpu_read(4'hC, d, r);
    chk("rand_status", d, 32'h0000_0002);

    // zero length start
    cpu_write(4'hC, 32'h2, 4'hF);
    cpu_write(4'h8, 32'd0, 4'hF);
    rd0 = rd_q.size();
    cpu_write(4'hC, 32'h1, 4'hF);
    chk("zero_irq_ready_cycle", {31'b0, irq}, 0);
    @(negedge clk);
    chk("zero_irq_next", {31'b0, irq}, 1);
    repeat (5) @(negedge clk);
    chk("zero_no_bus", 32'(rd_q.size() - rd0), 0);
    cpu_read(4'hC, d, r);
    chk("zero_status", d, 32'h0000_0002);

    // abort during the third read
    cpu_write(4'hC, 32'h2, 4'hF);
    set_lat(4, 4);
    cpu_write(4'h0, 32'h300, 4'hF);
    cpu_write(4'h4, 32'h400, 4'hF);
    cpu_write(4'h8, 32'd8, 4'hF);
    rd0 = rd_q.size(); wa0 = wa_q.size();
    cpu_write(4'hC, 32'h1, 4'hF);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_ren && wa_q.size() == wa0 + 2) begin found = 1; break; end
    end
    chk("abort_found_rd3", {31'b0, found}, 1);
    cpu_write(4'hC, 32'h4, 4'hF);
    wait_idle("abort_idle");
    chk("abort_nrd", 32'(rd_q.size() - rd0), 3);
    chk("abort_nwr", 32'(wa_q.size() - wa0), 2);
    cpu_read(4'hC, d, r);
    chk("abort_status", d, 32'h0006_0004);
    cpu_read(4'h0, d, r);
    chk("abort_src", d, 32'h308);

    // address wrap, busy writes ignored, start clears aborted
    set_lat(2, 2);
    cpu_write(4'h0, 32'hFFFF_FFFC, 4'hF);
    cpu_write(4'h4, 32'h500, 4'hF);
    cpu_write(4'h8, 32'd2, 4'hF);
    rd0 = rd_q.size(); wa0 = wa_q.size();
    cpu_write(4'hC, 32'h1, 4'hF);
    cpu_write(4'h0, 32'h0, 4'hF);
    cpu_read(4'hC, d, r);
    chk("wrap_busy_status", d, 32'h0002_0001);
    wait_idle("wrap_idle");
    chk("wrap_nrd", 32'(rd_q.size() - rd0), 2);
    if (rd_q.size() >= rd0 + 2 && wd_q.size() >= wa0 + 2) begin
      chk("wrap_rd1", rd_q[rd0+1], 32'h0);
      chk("wrap_wd0", wd_q[wa0], 32'hA5A5_FFFC);
    end
    cpu_read(4'h0, d, r);
    chk("wrap_src_end", d, 32'h0000_0004);

    // reset during a write
    cpu_write(4'hC, 32'h2, 4'hF);
    set_lat(3, 3);
    cpu_write(4'h0, 32'h600, 4'hF);
    cpu_write(4'h4, 32'h700, 4'hF);
    cpu_write(4'h8, 32'd4, 4'hF);
    cpu_write(4'hC, 32'h1, 4'hF);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_wen) begin found = 1; break; end
    end
    chk("rst_found_wr", {31'b0, found}, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_wen", {31'b0, bus_wen}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    rd0 = rd_q.size(); wa0 = wa_q.size();
    repeat (8) @(negedge clk);
    chk("rst_no_bus", 32'((rd_q.size() - rd0) + (wa_q.size() - wa0)), 0);
    for (int k = 0; k < 4; k++) begin
      cpu_read(4'(k * 4), d, r);
      chk("rst_reg_zero", d, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
